// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one 64-bit Booth multiplier between two requesters.
// Sequences the start/operand-load protocol, captures the 128-bit product and guards WAIT with a watchdog.
module mul_sched #(
   parameter int TIMEOUT = 200
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [63:0]  req_x0,
   input  logic [63:0]  req_y0,
   input  logic [63:0]  req_x1,
   input  logic [63:0]  req_y1,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic         resp_id,
   output logic [127:0] resp_prod,
   output logic         resp_err,
   output logic         mul_bgn,
   output logic [63:0]  mul_inbus,
   input  logic         mul_stop,
   input  logic [63:0]  mul_outbus,
   output logic [2:0]   dbg_state
);

   localparam int WDW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LDX  = 3'd1,
      LDY  = 3'd2,
      WAIT = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t          state;
   logic            last;
   logic            op_id;
   logic [63:0]     op_x;
   logic [63:0]     op_y;
   logic [63:0]     prev_word;
   logic [WDW-1:0]  wd;
   logic [1:0]      grant;

   assign dbg_state = state;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant = 2'b00;
      if (req_valid == 2'b11)
         grant = last ? 2'b01 : 2'b10;
      else
         grant = req_valid;
   end

   // Outputs are registered alongside the state, so every output is valid in the
   // same cycle the state register names. IDLE holds for the grant cycle itself.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state      <= IDLE;
         last       <= 1'b1;
         op_id      <= 1'b0;
         op_x       <= '0;
         op_y       <= '0;
         prev_word  <= '0;
         wd         <= '0;
         req_ready  <= 2'b00;
         resp_valid <= 1'b0;
         resp_id    <= 1'b0;
         resp_prod  <= '0;
         resp_err   <= 1'b0;
         mul_bgn    <= 1'b0;
         mul_inbus  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_ready != 2'b00) begin
                  req_ready <= 2'b00;
                  mul_bgn   <= 1'b1;
                  mul_inbus <= op_x;
                  state     <= LDX;
               end else if (req_valid != 2'b00) begin
                  req_ready <= grant;
                  op_id     <= grant[1];
                  op_x      <= grant[1] ? req_x1 : req_x0;
                  op_y      <= grant[1] ? req_y1 : req_y0;
               end
            end
            LDX: begin
               mul_bgn   <= 1'b0;
               mul_inbus <= op_y;
               state     <= LDY;
            end
            LDY: begin
               mul_inbus <= '0;
               wd        <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               // The multiplier presents the high word one cycle ahead of the low word.
               prev_word <= mul_outbus;
               if (mul_stop) begin
                  resp_prod  <= {prev_word, mul_outbus};
                  resp_err   <= 1'b0;
                  resp_id    <= op_id;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else if (wd == WDW'(TIMEOUT)) begin
                  resp_prod  <= '0;
                  resp_err   <= 1'b1;
                  resp_id    <= op_id;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  last       <= resp_id;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mul_sched.md
# mul_sched

Two-port scheduler that shares one 64-bit radix-2 Booth multiplier between two requesters in the ALU-64 datapath. It arbitrates round-robin, sequences the multiplier's start/operand-load protocol over its shared 64-bit input bus, and captures the 128-bit product from the multiplier's output bus. It returns the product to the granted requester with a valid/ready response. A watchdog flags a multiplier that never signals completion.

## Interface
- TIMEOUT, 200: number of cycles in WAIT before an error response; must be >= 70.
- clk  in  1  clock; all state updates on the rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request; held until accepted.
- req_ready  out  2  one-hot accept; high for one cycle to the granted requester only.
- req_x0, req_y0  in  64 each  requester 0 multiplicand and multiplier, signed two's complement.
- req_x1, req_y1  in  64 each  requester 1 operands.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumer accepts.
- resp_id  out  1  requester that owns the response.
- resp_prod  out  128  signed product, {high word, low word}.
- resp_err  out  1  watchdog expired; resp_prod is 0 when set.
- mul_bgn  out  1  one-cycle start pulse to the multiplier.
- mul_inbus  out  64  operand bus to the multiplier.
- mul_stop  in  1  multiplier completion pulse.
- mul_outbus  in  64  multiplier result bus.

## Operation
- One operation outstanding at most. States: IDLE, LDX, LDY, WAIT, RESP.
- IDLE: if any req_valid bit is high, grant per round-robin pointer `last`. Requester 0 has priority after a grant to 1 and after reset, and requester 1 has priority after a grant to 0. Assert req_ready[g] and latch the operands and id, then go to LDX. With no request, stay in IDLE.
- LDX: mul_bgn=1, mul_inbus=latched x, then go to LDY.
- LDY: mul_inbus=latched y, then go to WAIT. The watchdog counter is cleared on entry.
- WAIT: register mul_outbus every cycle into `prev_word`. When mul_stop=1, the high word is `prev_word` (the bus value of the previous cycle) and the low word is the current mul_outbus. Latch {prev_word, mul_outbus}, set resp_err=0, and go to RESP. Otherwise increment the watchdog. When it reaches TIMEOUT, set resp_prod=0 and resp_err=1, then go to RESP.
- RESP: resp_valid=1, with resp_id, resp_prod and resp_err stable. When resp_ready=1, go to IDLE and update `last` to resp_id. No new grant occurs in the same cycle as response acceptance.
- mul_inbus is 0 in every state other than LDX and LDY. mul_bgn is 0 in every state other than LDX.
- mul_stop outside WAIT is ignored.
- Req_valid dropping after a grant has no effect; the latched operands are used.

## Timing
- Reset values: state=IDLE, `last`=1 (requester 0 wins first), req_ready=0, resp_valid=0, resp_id=0, resp_prod=0, resp_err=0, mul_bgn=0, mul_inbus=0, watchdog=0, prev_word=0.
- Asserting rst_b low mid-operation returns to IDLE immediately and discards the operation. The multiplier shares rst_b.
- Grant cycle G: req_ready high in G. mul_bgn and x are on the bus in G+1. y is on the bus in G+2. WAIT begins at G+3.
- If mul_stop arrives in cycle S, resp_valid is high from S+1.
- Minimum request-to-request spacing is 5 cycles plus the multiplier latency plus the response hold time.
- Simultaneous requests are alternated strictly. A continuously requesting port is granted at most every other operation while the other port is requesting.
- Watchdog error: resp_valid rises TIMEOUT+1 cycles after WAIT entry.
- All outputs are registered (Moore). There is no combinational path from any input to any output except resp_ready, which acts only on the next edge.

## Test plan
- Single request: requester 0 sends x=3, y=-5. Expect req_ready[0] for 1 cycle, then mul_bgn with inbus=3, then inbus=-5, then resp_prod=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1, resp_id=0, resp_err=0.
- Both ports valid continuously for 4 operations with distinct operands: grants go 0,1,0,1. Each product matches the reference model for its id.
- Backpressure: hold resp_ready=0 for 10 cycles. resp_valid and data stay stable, there is no new req_ready, and the grant follows 1 cycle after acceptance.
- Extremes: x=y=64'h8000_0000_0000_0000 gives 128'h4000_0000_0000_0000_0000_0000_0000_0000. x=-1, y=-1 gives 1.
- Watchdog: stub the multiplier to never assert mul_stop with TIMEOUT=100. Expect resp_err=1 and resp_prod=0 exactly 101 cycles after WAIT entry, and the next request is served normally.
- Reset mid-WAIT: deassert rst_b asynchronously. All outputs reach reset values without waiting for a clock edge. After release, a new request completes correctly and requester 0 wins a tie.
